// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU issue controller.
// Holds ALU control codes, RV32I opcode/funct fields and FSM states.
package alu_pkg;

    localparam int DATA_W = 32;

    typedef logic [3:0] alu_ctrl_t;

    localparam alu_ctrl_t ALU_ADD = 4'b0000;
    localparam alu_ctrl_t ALU_SUB = 4'b0001;
    localparam alu_ctrl_t ALU_AND = 4'b0010;
    localparam alu_ctrl_t ALU_OR  = 4'b0011;
    localparam alu_ctrl_t ALU_XOR = 4'b0100;
    localparam alu_ctrl_t ALU_SLL = 4'b1000;
    localparam alu_ctrl_t ALU_SRL = 4'b1001;
    localparam alu_ctrl_t ALU_SRA = 4'b1010;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_CMP,
        S_DONE
    } state_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Issue/result handshake bundle plus the ALU-facing signals.
// slave: the controller side; master: issuer, ALU and writeback side.
interface alu_issue_ctrl_if;
    import alu_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_op1;
    logic [DATA_W-1:0] alu_op2;
    alu_ctrl_t         alu_ctrl;
    logic [DATA_W-1:0] alu_res;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;
    logic              illegal;

    modport slave (
        input  in_valid, opcode, funct3, funct7,
        input  op_a, op_b, alu_res, out_ready,
        output in_ready, alu_op1, alu_op2, alu_ctrl,
        output out_valid, result, illegal
    );

    modport master (
        output in_valid, opcode, funct3, funct7,
        output op_a, op_b, alu_res, out_ready,
        input  in_ready, alu_op1, alu_op2, alu_ctrl,
        input  out_valid, result, illegal
    );

endinterface

// File: rtl/alu_op_decoder.sv
// Combinational RV32I OP/OP-IMM decoder to ALU control code and flags.
// Ports: i_opcode/i_funct3/i_funct7 in; o_ctrl, o_is_slt, o_is_sltu, o_is_shift, o_illegal out.
module alu_op_decoder
    import alu_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic [6:0] i_funct7,
    output alu_ctrl_t  o_ctrl,
    output logic       o_is_slt,
    output logic       o_is_sltu,
    output logic       o_is_shift,
    output logic       o_illegal
);

    logic w_op;
    logic w_imm;
    logic w_f7_base;
    logic w_f7_alt;

    assign w_op      = (i_opcode == OPC_OP);
    assign w_imm     = (i_opcode == OPC_OPIMM);
    assign w_f7_base = (i_funct7 == F7_BASE);
    assign w_f7_alt  = (i_funct7 == F7_ALT);

    always_comb begin
        o_ctrl     = ALU_ADD;
        o_is_slt   = 1'b0;
        o_is_sltu  = 1'b0;
        o_is_shift = 1'b0;
        unique case (i_funct3)
            F3_ADD: begin
                // OP-IMM has no SUBI: funct7 there is immediate bits
                o_ctrl = (w_op && w_f7_alt) ? ALU_SUB : ALU_ADD;
            end
            F3_SLL: begin
                o_ctrl     = ALU_SLL;
                o_is_shift = 1'b1;
            end
            F3_SLT: begin
                o_ctrl   = ALU_SUB;
                o_is_slt = 1'b1;
            end
            F3_SLTU: begin
                o_ctrl    = ALU_SUB;
                o_is_sltu = 1'b1;
            end
            F3_XOR: o_ctrl = ALU_XOR;
            F3_SRL: begin
                o_ctrl     = w_f7_alt ? ALU_SRA : ALU_SRL;
                o_is_shift = 1'b1;
            end
            F3_OR:  o_ctrl = ALU_OR;
            F3_AND: o_ctrl = ALU_AND;
            default: o_ctrl = ALU_ADD;
        endcase
    end

    always_comb begin
        o_illegal = 1'b1;
        unique case (1'b1)
            w_op: begin
                o_illegal = !(w_f7_base ||
                    (w_f7_alt && (i_funct3 == F3_ADD ||
                                  i_funct3 == F3_SRL)));
            end
            w_imm: begin
                o_illegal =
                    (i_funct3 == F3_SLL && !w_f7_base) ||
                    (i_funct3 == F3_SRL && !w_f7_base && !w_f7_alt);
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one decoded RV32I integer op to the external ALU and returns the result.
// Ports: clk, rst_n (async low), bus (alu_issue_ctrl_if.slave: in/out handshakes, ALU signals).
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_issue_ctrl_if.slave  bus
);

    state_t          r_state;
    state_t          w_next;
    logic            w_in_ready;
    logic            w_out_valid;
    logic            w_accept;

    logic [XLEN-1:0] r_op1;
    logic [XLEN-1:0] r_op2;
    alu_ctrl_t       r_ctrl;
    logic            r_slt;
    logic            r_sltu;
    logic [XLEN-1:0] r_diff;
    logic [XLEN-1:0] r_result;
    logic            r_illegal;

    alu_ctrl_t       w_dec_ctrl;
    logic            w_dec_slt;
    logic            w_dec_sltu;
    logic            w_dec_shift;
    logic            w_dec_ill;
    logic [XLEN-1:0] w_op2;
    logic            w_ovf;
    logic            w_lt;

    alu_op_decoder u_dec (
        .i_opcode   (bus.opcode),
        .i_funct3   (bus.funct3),
        .i_funct7   (bus.funct7),
        .o_ctrl     (w_dec_ctrl),
        .o_is_slt   (w_dec_slt),
        .o_is_sltu  (w_dec_sltu),
        .o_is_shift (w_dec_shift),
        .o_illegal  (w_dec_ill)
    );

    assign w_accept = (r_state == S_IDLE) && bus.in_valid;

    assign w_op2 = w_dec_shift
        ? {{(XLEN-SHAMT_W){1'b0}}, bus.op_b[SHAMT_W-1:0]}
        : bus.op_b;

    // Sign compare from a-b: overflow flips the sign bit of d.
    // Unsigned compare: differing MSBs decide directly, else borrow = d[31].
    assign w_ovf = (r_op1[XLEN-1] != r_op2[XLEN-1]) &&
                   (r_diff[XLEN-1] != r_op1[XLEN-1]);
    assign w_lt  = r_slt
        ? (r_diff[XLEN-1] ^ w_ovf)
        : ((r_op1[XLEN-1] != r_op2[XLEN-1])
            ? r_op2[XLEN-1] : r_diff[XLEN-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_next = w_dec_ill ? S_DONE : S_EXEC;
                end
            end
            S_EXEC: begin
                w_next = (r_slt || r_sltu) ? S_CMP : S_DONE;
            end
            S_CMP: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op1     <= '0;
            r_op2     <= '0;
            r_ctrl    <= ALU_ADD;
            r_slt     <= 1'b0;
            r_sltu    <= 1'b0;
            r_diff    <= '0;
            r_result  <= '0;
            r_illegal <= 1'b0;
        end else begin
            if (w_accept) begin
                r_illegal <= w_dec_ill;
                if (w_dec_ill) begin
                    r_result <= '0;
                end else begin
                    // ALU inputs only move on a legal accept
                    r_op1  <= bus.op_a;
                    r_op2  <= w_op2;
                    r_ctrl <= w_dec_ctrl;
                    r_slt  <= w_dec_slt;
                    r_sltu <= w_dec_sltu;
                end
            end
            if (r_state == S_EXEC) begin
                if (r_slt || r_sltu) begin
                    r_diff <= bus.alu_res;
                end else begin
                    r_result <= bus.alu_res;
                end
            end
            if (r_state == S_CMP) begin
                r_result <= {{(XLEN-1){1'b0}}, w_lt};
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.alu_op1   = r_op1;
    assign bus.alu_op2   = r_op2;
    assign bus.alu_ctrl  = r_ctrl;
    assign bus.result    = r_result;
    assign bus.illegal   = r_illegal;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU.
// Table of vectors plus backpressure and mid-op reset sequences.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;

    alu_issue_ctrl_if bus ();

    alu_issue_ctrl #(
        .XLEN    (32),
        .SHAMT_W (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        bus.alu_res = '0;
        case (bus.alu_ctrl)
            ALU_ADD: bus.alu_res = bus.alu_op1 + bus.alu_op2;
            ALU_SUB: bus.alu_res = bus.alu_op1 - bus.alu_op2;
            ALU_AND: bus.alu_res = bus.alu_op1 & bus.alu_op2;
            ALU_OR:  bus.alu_res = bus.alu_op1 | bus.alu_op2;
            ALU_XOR: bus.alu_res = bus.alu_op1 ^ bus.alu_op2;
            ALU_SLL: bus.alu_res = bus.alu_op1 << bus.alu_op2[4:0];
            ALU_SRL: bus.alu_res = bus.alu_op1 >> bus.alu_op2[4:0];
            ALU_SRA: bus.alu_res =
                $signed(bus.alu_op1) >>> bus.alu_op2[4:0];
            default: bus.alu_res = 32'hDEAD_BEEF;
        endcase
    end

    typedef struct {
        string       name;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ill;
        int          lat;
        logic [3:0]  ctrl;
        logic [31:0] op2;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] opc,
                         input logic [2:0] f3,
                         input logic [6:0] f7,
                         input logic [31:0] a,
                         input logic [31:0] b);
        bus.opcode   = opc;
        bus.funct3   = f3;
        bus.funct7   = f7;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.in_valid = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        chk({v.name, ".in_ready"}, {31'b0, bus.in_ready}, 32'd1);
        drive(v.opc, v.f3, v.f7, v.a, v.b);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({v.name, ".lat"}, lat, v.lat);
        chk({v.name, ".res"}, bus.result, v.res);
        chk({v.name, ".ill"}, {31'b0, bus.illegal}, {31'b0, v.ill});
        if (!v.ill) begin
            chk({v.name, ".ctrl"}, {28'b0, bus.alu_ctrl}, {28'b0, v.ctrl});
            chk({v.name, ".op2"}, bus.alu_op2, v.op2);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({v.name, ".idle"}, {30'b0, bus.in_ready, bus.out_valid},
            32'd2);
    endtask

    initial begin
        logic [31:0] held;
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.opcode    = '0;
        bus.funct3    = '0;
        bus.funct7    = '0;
        bus.op_a      = '0;
        bus.op_b      = '0;

        vecs[0]  = '{"add", OPC_OP, 3'b000, 7'h00, 32'h7FFFFFFF,
                     32'h1, 32'h80000000, 1'b0, 2, 4'b0000, 32'h1};
        vecs[1]  = '{"srai", OPC_OPIMM, 3'b101, 7'h20, 32'h80000000,
                     32'h404, 32'hF8000000, 1'b0, 2, 4'b1010, 32'h4};
        vecs[2]  = '{"slt_neg", OPC_OP, 3'b010, 7'h00, 32'hFFFFFFFF,
                     32'h1, 32'h1, 1'b0, 3, 4'b0001, 32'h1};
        vecs[3]  = '{"sltu_big", OPC_OP, 3'b011, 7'h00, 32'hFFFFFFFF,
                     32'h1, 32'h0, 1'b0, 3, 4'b0001, 32'h1};
        vecs[4]  = '{"slt_ovf", OPC_OP, 3'b010, 7'h00, 32'h80000000,
                     32'h1, 32'h1, 1'b0, 3, 4'b0001, 32'h1};
        vecs[5]  = '{"ill_op", OPC_OP, 3'b001, 7'h20, 32'h5,
                     32'h6, 32'h0, 1'b1, 1, 4'b0000, 32'h0};
        vecs[6]  = '{"ill_opc", 7'b0000011, 3'b000, 7'h00, 32'h5,
                     32'h6, 32'h0, 1'b1, 1, 4'b0000, 32'h0};
        vecs[7]  = '{"sub", OPC_OP, 3'b000, 7'h20, 32'h5,
                     32'h7, 32'hFFFFFFFE, 1'b0, 2, 4'b0001, 32'h7};
        vecs[8]  = '{"andi", OPC_OPIMM, 3'b111, 7'h7F, 32'h12345678,
                     32'hFFFFFF0F, 32'h12345608, 1'b0, 2, 4'b0010,
                     32'hFFFFFF0F};
        vecs[9]  = '{"xor", OPC_OP, 3'b100, 7'h00, 32'hFF00FF00,
                     32'h0F0F0F0F, 32'hF00FF00F, 1'b0, 2, 4'b0100,
                     32'h0F0F0F0F};
        vecs[10] = '{"or", OPC_OP, 3'b110, 7'h00, 32'h000000F0,
                     32'h00000F00, 32'h00000FF0, 1'b0, 2, 4'b0011,
                     32'h00000F00};
        vecs[11] = '{"sll", OPC_OP, 3'b001, 7'h00, 32'h1,
                     32'hFFFFFFE3, 32'h8, 1'b0, 2, 4'b1000, 32'h3};
        vecs[12] = '{"srl", OPC_OP, 3'b101, 7'h00, 32'h80000000,
                     32'd31, 32'h1, 1'b0, 2, 4'b1001, 32'd31};
        vecs[13] = '{"ill_slli", OPC_OPIMM, 3'b001, 7'h20, 32'h1,
                     32'h401, 32'h0, 1'b1, 1, 4'b0000, 32'h0};
        vecs[14] = '{"sltiu", OPC_OPIMM, 3'b011, 7'h7F, 32'h1,
                     32'hFFFFFFFF, 32'h1, 1'b0, 3, 4'b0001,
                     32'hFFFFFFFF};
        vecs[15] = '{"addi_f7", OPC_OPIMM, 3'b000, 7'h20, 32'hA,
                     32'h400, 32'h40A, 1'b0, 2, 4'b0000, 32'h400};
        vecs[16] = '{"ill_srai", OPC_OPIMM, 3'b101, 7'h21, 32'h1,
                     32'h421, 32'h0, 1'b1, 1, 4'b0000, 32'h0};
        vecs[17] = '{"slt_pos", OPC_OP, 3'b010, 7'h00, 32'h5,
                     32'h3, 32'h0, 1'b0, 3, 4'b0001, 32'h3};

        #12;
        chk("rst.in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("rst.out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst.illegal", {31'b0, bus.illegal}, 32'd0);
        chk("rst.result", bus.result, 32'd0);
        chk("rst.op1", bus.alu_op1, 32'd0);
        chk("rst.op2", bus.alu_op2, 32'd0);
        chk("rst.ctrl", {28'b0, bus.alu_ctrl}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i]);
        end

        // backpressure: result held, new requests ignored
        drive(OPC_OP, 3'b000, 7'h00, 32'd100, 32'd23);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        held = bus.result;
        chk("bp.first", held, 32'd123);
        drive(OPC_OP, 3'b100, 7'h00, 32'hFFFF, 32'h1);
        for (int c = 0; c < 5; c++) begin
            chk("bp.valid", {31'b0, bus.out_valid}, 32'd1);
            chk("bp.result", bus.result, 32'd123);
            chk("bp.in_ready", {31'b0, bus.in_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("bp.release", {30'b0, bus.in_ready, bus.out_valid}, 32'd2);
        @(posedge clk);
        #1;
        chk("bp.no_stray", {30'b0, bus.in_ready, bus.out_valid}, 32'd2);

        // reset during EXEC aborts the op
        drive(OPC_OP, 3'b100, 7'h00, 32'h0F, 32'hF0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("mid.exec_ctrl", {28'b0, bus.alu_ctrl}, 32'd4);
        rst_n = 1'b0;
        #1;
        chk("mid.out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("mid.in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("mid.ctrl", {28'b0, bus.alu_ctrl}, 32'd0);
        chk("mid.result", bus.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            chk("mid.no_stale", {31'b0, bus.out_valid}, 32'd0);
        end
        run_vec(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
